// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the multicycle RV32I controller and its datapath.
// master: controller side. It reads the instruction fields, ALU flags and mem_ready,
//         and drives the selects, write enables, retire and state_dbg.
// slave:  datapath side, with every direction reversed.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       retire;
    logic [3:0] state_dbg;
    modport master (
        input  op, funct3, funct7b5, zero, lt, ltu, mem_ready,
        output imm_src, alu_src_a, alu_src_b, alu_op, result_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, retire, state_dbg
    );
    modport slave (
        output op, funct3, funct7b5, zero, lt, ltu, mem_ready,
        input  imm_src, alu_src_a, alu_src_b, alu_op, result_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, retire, state_dbg
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core (fetch/decode/execute/memory/writeback).
// Ports: clk, reset (synchronous, active-high), bus (multicycle_ctrl_if.master: instruction
//        fields, ALU flags and mem_ready in; datapath selects, write enables, retire and state_dbg out).
// With CTRL_ILLEGAL_TRAP_EN defined, an unknown opcode parks the FSM in TRAP and the extra
// output illegal is raised. Without it, an unknown opcode retires as a NOP.
module multicycle_ctrl (
    input  logic clk,
    input  logic reset,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic illegal,
`endif
    multicycle_ctrl_if.master bus
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BRANCH, JAL, JALR, LUI
`ifdef CTRL_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    typedef struct packed {
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       adr_src;
        logic       reg_write;
        logic       mem_write;
        logic       retire;
    } moore_t;

    state_t state, nxt, dec_nxt;
    moore_t mo;
    logic   taken;
    logic   unused_funct7b5;

    // Moore outputs of a state; they are registered from the next state so they line up with it.
    function automatic moore_t moore(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            FETCH:    begin m.alu_src_b = 2'b10; m.result_src = 2'b10; end
            DECODE:   begin m.alu_src_a = 2'b01; m.alu_src_b = 2'b01; end
            MEMADR:   begin m.alu_src_a = 2'b10; m.alu_src_b = 2'b01; end
            MEMREAD:  m.adr_src = 1'b1;
            MEMWB:    begin m.result_src = 2'b01; m.reg_write = 1'b1; m.retire = 1'b1; end
            MEMWRITE: begin m.adr_src = 1'b1; m.mem_write = 1'b1; end
            EXECR:    begin m.alu_src_a = 2'b10; m.alu_op = 2'b10; end
            EXECI:    begin m.alu_src_a = 2'b10; m.alu_src_b = 2'b01; m.alu_op = 2'b10; end
            ALUWB:    begin m.reg_write = 1'b1; m.retire = 1'b1; end
            BRANCH:   begin m.alu_src_a = 2'b10; m.alu_op = 2'b01; m.retire = 1'b1; end
            JAL:      begin m.alu_src_a = 2'b01; m.alu_src_b = 2'b10; end
            JALR:     begin m.alu_src_a = 2'b10; m.alu_src_b = 2'b01; end
            LUI:      begin m.alu_src_b = 2'b01; m.alu_op = 2'b11; end
            default:  ;
        endcase
        return m;
    endfunction

    always_comb begin
        dec_nxt = FETCH;
        case (bus.op)
            OP_LOAD, OP_STORE: dec_nxt = MEMADR;
            OP_R:              dec_nxt = EXECR;
            OP_I:              dec_nxt = EXECI;
            OP_BR:             dec_nxt = BRANCH;
            OP_JAL:            dec_nxt = JAL;
            OP_JALR:           dec_nxt = JALR;
            OP_LUI:            dec_nxt = LUI;
            OP_AUIPC:          dec_nxt = ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
            default:           dec_nxt = TRAP;
`else
            default:           dec_nxt = FETCH;
`endif
        endcase
    end

    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:                   nxt = bus.mem_ready ? DECODE : FETCH;
            DECODE:                  nxt = dec_nxt;
            MEMADR:                  nxt = bus.op == OP_LOAD ? MEMREAD : MEMWRITE;
            MEMREAD:                 nxt = bus.mem_ready ? MEMWB : MEMREAD;
            MEMWRITE:                nxt = bus.mem_ready ? FETCH : MEMWRITE;
            EXECR, EXECI, JAL, LUI:  nxt = ALUWB;
            JALR:                    nxt = JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP:                    nxt = TRAP;
`endif
            default:                 nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        state <= reset ? FETCH : nxt;
        mo    <= moore(reset ? FETCH : nxt);
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal <= !reset && (illegal || nxt == TRAP);
`endif
    end

    // funct3 = {kind[1:0], invert}: 00 eq, 10 signed lt, 11 unsigned lt; 01x never taken
    assign taken = bus.funct3[2:1] == 2'b01 ? 1'b0 :
                   bus.funct3[0] ^ (bus.funct3[2:1] == 2'b00 ? bus.zero : bus.funct3[1] ? bus.ltu : bus.lt);

    assign bus.imm_src = bus.op == OP_STORE ? 3'b001 :
                         bus.op == OP_BR    ? 3'b010 :
                         bus.op == OP_LUI   ? 3'b011 :
                         bus.op == OP_JAL   ? 3'b100 :
                         bus.op == OP_AUIPC ? 3'b101 : 3'b000;

    assign bus.alu_src_a  = mo.alu_src_a;
    assign bus.alu_src_b  = mo.alu_src_b;
    assign bus.alu_op     = mo.alu_op;
    assign bus.result_src = mo.result_src;
    assign bus.adr_src    = mo.adr_src;
    assign bus.state_dbg  = state;

    // Enables and retire are gated by reset so nothing commits in a reset cycle.
    assign bus.ir_write  = !reset && state == FETCH && bus.mem_ready;
    assign bus.pc_write  = !reset && ((state == FETCH && bus.mem_ready) || state == JAL || (state == BRANCH && taken));
    assign bus.reg_write = !reset && mo.reg_write;
    assign bus.mem_write = !reset && mo.mem_write;
    // A DECODE that falls straight back to FETCH is the NOP for an unknown opcode.
    assign bus.retire    = !reset && (mo.retire || (state == MEMWRITE && bus.mem_ready) || (state == DECODE && dec_nxt == FETCH));

    assign unused_funct7b5 = bus.funct7b5;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized self-checking bench for multicycle_ctrl against a per-instruction model.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [6:0] ops [10] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'b0000000};

    multicycle_ctrl_if bus();
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal;
`endif

    multicycle_ctrl dut (
        .clk(clk),
        .reset(reset),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_imm(input logic [6:0] o);
        case (o)
            OP_STORE: return 3'b001;
            OP_BR:    return 3'b010;
            OP_LUI:   return 3'b011;
            OP_JAL:   return 3'b100;
            OP_AUIPC: return 3'b101;
            default:  return 3'b000;
        endcase
    endfunction

    function automatic int base_cycles(input logic [6:0] o);
        case (o)
            OP_AUIPC, OP_BR:                        return 3;
            OP_R, OP_I, OP_LUI, OP_STORE, OP_JAL:   return 4;
            OP_LOAD, OP_JALR:                       return 5;
            default:                                return 2;
        endcase
    endfunction

    function automatic bit br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Runs one instruction from its first FETCH cycle; fw = fetch wait cycles, mw = data wait cycles.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input int fw, input int mw, input string tag);
        int exp_len, exp_pw, cyc, ms, rw_cyc;
        int n_rw, n_mw, n_pw, n_ir, n_adr, n_imm, n_op10, n_op01, n_op11;
        logic [1:0] rs_rw;
        bit memop, wb, done;
        memop = o == OP_LOAD || o == OP_STORE;
        wb = o inside {OP_LOAD, OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
        exp_len = base_cycles(o) + fw + (memop ? mw : 0);
        exp_pw = 1 + ((o == OP_JAL || o == OP_JALR) ? 1 : 0) + ((o == OP_BR && br_taken(f3, a, b)) ? 1 : 0);
        bus.op = o;
        bus.funct3 = f3;
        bus.funct7b5 = 1'($urandom_range(0, 1));
        bus.zero = a == b;
        bus.lt = $signed(a) < $signed(b);
        bus.ltu = a < b;
        ms = fw + 3;
        cyc = 0; rw_cyc = 0; rs_rw = 2'b11; done = 0;
        n_rw = 0; n_mw = 0; n_pw = 0; n_ir = 0; n_adr = 0; n_imm = 0; n_op10 = 0; n_op01 = 0; n_op11 = 0;
        while (!done && cyc < exp_len + 20) begin
            bus.mem_ready = !(cyc < fw || (memop && cyc >= ms && cyc < ms + mw));
            @(negedge clk);
            cyc++;
            n_rw += int'(bus.reg_write);
            n_mw += int'(bus.mem_write);
            n_pw += int'(bus.pc_write);
            n_ir += int'(bus.ir_write);
            n_adr += int'(bus.adr_src);
            if (bus.imm_src !== exp_imm(o)) n_imm++;
            if (bus.alu_op === 2'b10) n_op10++;
            if (bus.alu_op === 2'b01) n_op01++;
            if (bus.alu_op === 2'b11) n_op11++;
            if (bus.reg_write) begin rs_rw = bus.result_src; rw_cyc = cyc; end
            done = bus.retire;
            @(posedge clk); #1;
        end
        checks++; if (!done || cyc != exp_len) begin errors++; $display("FAIL %s length: %0d cycles (retired=%0b), expected %0d", tag, cyc, done, exp_len); end
        checks++; if (n_ir != 1) begin errors++; $display("FAIL %s ir_write count: %0d, expected 1", tag, n_ir); end
        checks++; if (n_pw != exp_pw) begin errors++; $display("FAIL %s pc_write count: %0d, expected %0d", tag, n_pw, exp_pw); end
        checks++; if (n_rw != (wb ? 1 : 0)) begin errors++; $display("FAIL %s reg_write count: %0d, expected %0d", tag, n_rw, wb); end
        checks++; if (n_mw != (o == OP_STORE ? mw + 1 : 0)) begin errors++; $display("FAIL %s mem_write count: %0d, expected %0d", tag, n_mw, o == OP_STORE ? mw + 1 : 0); end
        checks++; if (n_adr != (memop ? mw + 1 : 0)) begin errors++; $display("FAIL %s adr_src count: %0d, expected %0d", tag, n_adr, memop ? mw + 1 : 0); end
        checks++; if (n_imm != 0) begin errors++; $display("FAIL %s imm_src wrong in %0d cycles, expected %b always", tag, n_imm, exp_imm(o)); end
        checks++; if (n_op10 != ((o == OP_R || o == OP_I) ? 1 : 0)) begin errors++; $display("FAIL %s alu_op=10 cycles: %0d", tag, n_op10); end
        checks++; if (n_op01 != (o == OP_BR ? 1 : 0)) begin errors++; $display("FAIL %s alu_op=01 cycles: %0d", tag, n_op01); end
        checks++; if (n_op11 != (o == OP_LUI ? 1 : 0)) begin errors++; $display("FAIL %s alu_op=11 cycles: %0d", tag, n_op11); end
        if (wb) begin
            checks++;
            if (rw_cyc != exp_len || rs_rw !== (o == OP_LOAD ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL %s writeback: cycle %0d result_src %b, expected cycle %0d result_src %b",
                                   tag, rw_cyc, rs_rw, exp_len, o == OP_LOAD ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1; bus.mem_ready = 1; bus.op = OP_R; bus.funct3 = 0; bus.funct7b5 = 0;
        bus.zero = 1; bus.lt = 1; bus.ltu = 1;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.retire} !== 5'b0 ||
                bus.alu_src_b !== 2'b10 || bus.result_src !== 2'b10) begin
                errors++; $display("FAIL reset: enables %b b=%b rs=%b, expected 00000 b=10 rs=10",
                                   {bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.retire}, bus.alu_src_b, bus.result_src);
            end
            @(posedge clk);
        end
        #1 reset = 0;
    endtask

    task automatic test_add();
        run_instr(OP_R, 3'b000, 32'd3, 32'd4, 0, 0, "add");
    endtask

    task automatic test_load_wait();
        run_instr(OP_LOAD, 3'b010, 32'd0, 32'd0, 0, 2, "lw_wait");
    endtask

    task automatic test_branch();
        run_instr(OP_BR, 3'b000, 32'd5, 32'd5, 0, 0, "beq_taken");
        run_instr(OP_BR, 3'b001, 32'd5, 32'd5, 0, 0, "bne_not_taken");
        run_instr(OP_BR, 3'b100, 32'hffff_fff0, 32'd1, 1, 0, "blt_taken");
        run_instr(OP_BR, 3'b110, 32'hffff_fff0, 32'd1, 0, 0, "bltu_not_taken");
    endtask

    task automatic test_jump();
        run_instr(OP_JALR, 3'b000, 32'd0, 32'd0, 0, 0, "jalr");
        run_instr(OP_JAL, 3'b000, 32'd0, 32'd0, 0, 0, "jal");
        run_instr(OP_AUIPC, 3'b000, 32'd0, 32'd0, 0, 0, "auipc");
        run_instr(OP_STORE, 3'b010, 32'd0, 32'd0, 1, 2, "sw_wait");
    endtask

    task automatic test_reset_mid();
        bus.op = OP_STORE; bus.funct3 = 3'b010; bus.mem_ready = 1;
        repeat (3) begin @(posedge clk); #1; end
        bus.mem_ready = 0;
        @(negedge clk);
        checks++; if (bus.mem_write !== 1'b1 || bus.adr_src !== 1'b1) begin errors++; $display("FAIL sw_memwrite: mem_write=%b adr_src=%b, expected 1 1", bus.mem_write, bus.adr_src); end
        @(posedge clk); #1;
        reset = 1; bus.mem_ready = 1;
        @(negedge clk);
        checks++;
        if ({bus.mem_write, bus.retire, bus.pc_write, bus.reg_write, bus.ir_write} !== 5'b0) begin
            errors++; $display("FAIL reset_in_memwrite: mw/ret/pw/rw/ir=%b, expected 00000", {bus.mem_write, bus.retire, bus.pc_write, bus.reg_write, bus.ir_write});
        end
        @(posedge clk); #1;
        reset = 0; bus.mem_ready = 0;
        @(negedge clk);
        checks++;
        if (bus.ir_write !== 1'b0 || bus.adr_src !== 1'b0 || bus.alu_src_b !== 2'b10 || bus.result_src !== 2'b10 || bus.mem_write !== 1'b0) begin
            errors++; $display("FAIL fetch_after_reset: ir=%b adr=%b b=%b rs=%b mw=%b, expected 0 0 10 10 0",
                               bus.ir_write, bus.adr_src, bus.alu_src_b, bus.result_src, bus.mem_write);
        end
        @(posedge clk); #1;
        run_instr(OP_STORE, 3'b010, 32'd0, 32'd0, 0, 1, "sw_after_reset");
    endtask

    task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
        bus.op = 7'b0000000; bus.mem_ready = 1;
        @(negedge clk);
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_before: %b, expected 0", illegal); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (illegal !== 1'b1 || {bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.retire} !== 5'b0) begin
                errors++; $display("FAIL trap_hold %0d: illegal=%b enables=%b, expected 1 00000", i, illegal,
                                   {bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.retire});
            end
            @(posedge clk); #1;
        end
        reset = 1;
        @(posedge clk); #1;
        reset = 0; bus.mem_ready = 0;
        @(negedge clk);
        checks++; if (illegal !== 1'b0 || bus.result_src !== 2'b10) begin errors++; $display("FAIL trap_reset: illegal=%b rs=%b, expected 0 10", illegal, bus.result_src); end
        @(posedge clk); #1;
`else
        run_instr(7'b0000000, 3'b000, 32'd0, 32'd0, 0, 0, "nop_unknown");
        run_instr(7'b1111111, 3'b000, 32'd0, 32'd0, 2, 0, "nop_unknown_wait");
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [6:0] o;
            logic [31:0] a, b;
            o = ops[$urandom_range(0, 9)];
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (o == 7'b0000000) o = OP_I;
`endif
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_instr(o, 3'($urandom_range(0, 7)), a, b, $urandom_range(0, 2), $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end
    endtask

    task automatic test_reset_random();
        for (int i = 0; i < 8; i++) begin
            bus.op = ops[$urandom_range(0, 9)]; bus.mem_ready = 1;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            reset = 1; bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.retire} !== 5'b0) begin
                errors++; $display("FAIL reset_random %0d: enables=%b, expected 00000", i,
                                   {bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.retire});
            end
            @(posedge clk); #1;
            reset = 0;
            run_instr(OP_R, 3'b000, 32'd1, 32'd2, 0, 0, $sformatf("add_after_reset%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_branch();
        test_jump();
        test_reset_mid();
        test_illegal();
        test_random();
        test_reset_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback over several cycles using the shared ALU, the shared instruction/data memory port and the immediate extender. It drives every datapath select and write enable, including `imm_src`, whose encodings match the extender. It waits on a memory-ready handshake during fetch and data accesses, and emits a one-cycle retire pulse per completed instruction.

## Interface
- `clk` in 1: system clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high. Forces state to FETCH and gates every write enable to 0 while high.
- `op` in 7: instruction[6:0], taken from the instruction register.
- `funct3` in 3: instruction[14:12].
- `funct7b5` in 1: instruction[30]; passed through for ALU decode and not used by the FSM.
- `zero`, `lt`, `ltu` in 1 each: ALU flags for rs1−rs2 (equal, signed less-than, unsigned less-than).
- `mem_ready` in 1: memory port has completed the current access this cycle.
- `imm_src` out 3: I/L/JALR=000, S=001, B=010, LUI=011, JAL=100, AUIPC=101. Any other opcode gives 000.
- `alu_src_a` out 2: 00 pc, 01 old_pc, 10 rd1.
- `alu_src_b` out 2: 00 rd2, 01 imm_ext, 10 constant 4.
- `alu_op` out 2: 00 add, 01 subtract/compare, 10 decode from funct fields, 11 pass B.
- `result_src` out 2: 00 alu_out (registered), 01 read data, 10 alu_result (combinational).
- `adr_src` out 1: 0 pc, 1 result.
- `ir_write`, `pc_write`, `reg_write`, `mem_write` out 1 each: write enables.
- `retire` out 1: one-cycle pulse in the final state of each instruction.
- `state_dbg` out 4: current state encoding.
- `illegal` out 1: sticky illegal-opcode flag; exists only when the macro is defined.

## Operation
- States, with Moore outputs; unlisted outputs are 0:
  - **FETCH**: adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write=pc_write=mem_ready. Stays in FETCH while !mem_ready; otherwise goes to DECODE.
  - **DECODE**: a=01, b=01, alu_op=00, so alu_out becomes the pc-relative target. Next state by op:
    - 0000011/0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → ALUWB
    - other → see Configuration.
  - **MEMADR**: a=10, b=01, add. Goes to MEMREAD if op=0000011, else MEMWRITE.
  - **MEMREAD**: adr_src=1, result_src=00. Waits for mem_ready, then goes to MEMWB.
  - **MEMWB**: result_src=01, reg_write=1, retire=1. Goes to FETCH.
  - **MEMWRITE**: adr_src=1, result_src=00, mem_write=1, held until mem_ready. On mem_ready: retire=1, go to FETCH.
  - **EXECR**: a=10, b=00, alu_op=10. Goes to ALUWB.
  - **EXECI**: a=10, b=01, alu_op=10. Goes to ALUWB.
  - **ALUWB**: result_src=00, reg_write=1, retire=1. Goes to FETCH.
  - **BRANCH**: a=10, b=00, alu_op=01, result_src=00, retire=1. pc_write=taken. Goes to FETCH.
  - **JAL**: a=01, b=10, result_src=00, pc_write=1. Goes to ALUWB.
  - **JALR**: a=10, b=01, add. Goes to JAL.
  - **LUI**: b=01, alu_op=11. Goes to ALUWB.
- `taken` by funct3:
  - 000 zero
  - 001 !zero
  - 100 lt
  - 101 !lt
  - 110 ltu
  - 111 !ltu
  - 010/011 never taken
- `imm_src` is decoded combinationally from `op` in every state, not only in DECODE.

## Timing
- After reset deasserts, the first active cycle is FETCH.
- Reset asserted mid-instruction: the next state is FETCH regardless of the current state. No write enable is asserted during the reset cycle.
- Cycles per instruction with mem_ready tied to 1:
  - AUIPC 3, branch 3
  - R, I, LUI, store, JAL: 4
  - load, JALR: 5
- Each wait cycle in FETCH, MEMREAD or MEMWRITE adds one cycle. mem_write stays asserted and the address stays stable throughout.
- `retire` fires exactly once per instruction, in the cycle before returning to FETCH.
- pc_write in BRANCH is Mealy on the flags, which must be valid in that cycle.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - Unknown op in DECODE goes to TRAP: all enables 0, retire=0, `illegal`=1.
  - TRAP holds until reset. `illegal` resets to 0.
- `CTRL_ILLEGAL_TRAP_EN` undefined:
  - Unknown op is a NOP: DECODE goes to FETCH with retire=1.
  - No TRAP state and no `illegal` port.

## Test plan
- Reset held 2 cycles, then add (op=0110011), mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB. reg_write=1 only in cycle 4; retire pulses in cycle 4.
- lw with mem_ready low for 2 cycles in MEMREAD → 7 cycles total; adr_src=1 throughout MEMREAD; reg_write with result_src=01 in MEMWB.
- beq with zero=1, then bne with zero=1 → pc_write=1 in BRANCH for the first and 0 for the second; imm_src=010 for both.
- jalr → JALR then JAL states with pc_write=1 in JAL, then ALUWB with result_src=00; imm_src=000. jal gives imm_src=100.
- sw with reset asserted during MEMWRITE → mem_write=0 in the reset cycle; state FETCH on the next cycle; retire not pulsed.
- op=0000000 → with `CTRL_ILLEGAL_TRAP_EN` defined, `illegal`=1 and state stays in TRAP for 10 cycles. With it undefined, retire pulses and FETCH follows DECODE.
